// File: rtl/moore_seq_det.sv
// Moore serial sequence detector with a runtime-reloadable WIDTH-bit pattern.
// Supports overlapping and non-overlapping matching. The match counter is built only when SEQDET_COUNT_EN is defined.
module moore_seq_det #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = 4'b1001,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [WIDTH-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int                FILL_W    = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);

  logic [WIDTH-1:0]  hist_reg;
  logic [WIDTH-1:0]  hist_next;
  logic [WIDTH-1:0]  pat_reg;
  logic [WIDTH-1:0]  bit_eq;
  logic [FILL_W-1:0] fill_reg;
  logic [FILL_W-1:0] fill_inc;
  logic [FILL_W-1:0] fill_next;
  logic              y_reg;
  logic              m;

  assign hist_next = {hist_reg[WIDTH-2:0], x};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit_eq
      assign bit_eq[gi] = ~(hist_next[gi] ^ pat_reg[gi]);
    end
  endgenerate

  always_comb begin
    fill_inc  = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + FILL_W'(1);
    m         = (fill_inc == FILL_FULL) && (&bit_eq);
    // Non-overlapping mode restarts the fill so the next match needs WIDTH fresh bits.
    fill_next = (m && !overlap) ? '0 : fill_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_reg <= '0;
      fill_reg <= '0;
      pat_reg  <= PATTERN;
      y_reg    <= 1'b0;
    end else if (pat_load) begin
      pat_reg  <= pat_in;
      hist_reg <= '0;
      fill_reg <= '0;
      y_reg    <= 1'b0;
    end else if (en) begin
      hist_reg <= hist_next;
      fill_reg <= fill_next;
      y_reg    <= m;
    end
  end

  assign y = y_reg;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_reg;

  // Clear wins over a simultaneous detection; the count saturates at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (cnt_clr) begin
      cnt_reg <= '0;
    end else if (!pat_load && en && m && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign match_cnt = cnt_reg;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_moore_seq_det.sv
// Directed self-checking bench for moore_seq_det (WIDTH=4, PATTERN=1001).
// A second instance with CNT_W=2 shares all inputs and is checked for counter saturation.
module tb_moore_seq_det;

  logic       clk = 1'b0;
  logic       reset, en, x, overlap, pat_load, cnt_clr;
  logic [3:0] pat_in;
  logic       y, y2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  moore_seq_det dut (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .y(y), .match_cnt(match_cnt)
  );

  moore_seq_det #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .y(y2), .match_cnt(match_cnt2)
  );

  // Expected counter value depends on whether the counter is built.
  function automatic int ec(input int n);
`ifdef SEQDET_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic exp_y, input string tag);
    x = b;
    tick();
    $display("%s: x=%0b y=%0b cnt=%0d", tag, b, y, match_cnt);
    chk(tag, {31'b0, y}, {31'b0, exp_y});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [6:0] stream7;
  logic [6:0] exp_ov, exp_nov;

  initial begin
    reset = 1'b1; en = 1'b0; x = 1'b0; overlap = 1'b0;
    pat_load = 1'b0; pat_in = 4'b0; cnt_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_y", {31'b0, y}, 32'd0);
    chk("reset_cnt", {24'b0, match_cnt}, 32'd0);

    // Overlapping: 1001001 detects after bits 4 and 7.
    stream7 = 7'b1001001;
    exp_ov  = 7'b0001001;
    exp_nov = 7'b0001000;
    overlap = 1'b1; en = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      send(stream7[i], exp_ov[i], "ovl");
      if (i == 3) chk("ovl_cnt_same_cycle", {24'b0, match_cnt}, ec(1));
    end
    chk("ovl_cnt", {24'b0, match_cnt}, ec(2));

    // Non-overlapping: only the first detection, then 1001 detects again.
    do_reset();
    overlap = 1'b0;
    for (int i = 6; i >= 0; i--) send(stream7[i], exp_nov[i], "novl");
    chk("novl_cnt1", {24'b0, match_cnt}, ec(1));
    send(1'b1, 1'b0, "novl_b");
    send(1'b0, 1'b0, "novl_b");
    send(1'b0, 1'b0, "novl_b");
    send(1'b1, 1'b1, "novl_b");
    chk("novl_cnt2", {24'b0, match_cnt}, ec(2));

    // Pattern reload to 1111; the load-cycle sample is discarded.
    do_reset();
    pat_load = 1'b1; pat_in = 4'b1111; overlap = 1'b1;
    send(1'b1, 1'b0, "load");
    pat_load = 1'b0;
    for (int i = 0; i < 6; i++) send(1'b1, (i >= 3), "reload");
    chk("reload_cnt", {24'b0, match_cnt}, ec(3));

    // Enable gating: 1,0, gap, 0,1 detects; held y=1 is not re-counted.
    do_reset();
    send(1'b1, 1'b0, "gate");
    send(1'b0, 1'b0, "gate");
    en = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, "gap0");
    en = 1'b1;
    send(1'b0, 1'b0, "gate");
    send(1'b1, 1'b1, "gate");
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 1'b1, "gap1");
      chk("gap1_cnt", {24'b0, match_cnt}, ec(1));
    end
    en = 1'b1;

    // Five overlapping detections: CNT_W=2 instance saturates at 3.
    do_reset();
    send(1'b1, 1'b0, "sat");
    send(1'b0, 1'b0, "sat");
    send(1'b0, 1'b0, "sat");
    send(1'b1, 1'b1, "sat");
    for (int k = 0; k < 4; k++) begin
      send(1'b0, 1'b0, "sat");
      send(1'b0, 1'b0, "sat");
      send(1'b1, 1'b1, "sat");
    end
    chk("sat_cnt8", {24'b0, match_cnt}, ec(5));
    chk("sat_cnt2", {30'b0, match_cnt2}, ec(3));
    chk("sat_y2", {31'b0, y2}, 32'd1);

    // Clear on a detecting edge wins, y still rises.
    send(1'b0, 1'b0, "clr");
    send(1'b0, 1'b0, "clr");
    cnt_clr = 1'b1;
    send(1'b1, 1'b1, "clr");
    cnt_clr = 1'b0;
    chk("clr_cnt8", {24'b0, match_cnt}, 32'd0);
    chk("clr_cnt2", {30'b0, match_cnt2}, 32'd0);

    // pat_load while y=1 drops y next cycle.
    pat_load = 1'b1; pat_in = 4'b1001;
    send(1'b1, 1'b0, "load_mid");
    pat_load = 1'b0;

    // Reset after partial 1,0,0 loses progress.
    send(1'b1, 1'b0, "rst_mid");
    send(1'b0, 1'b0, "rst_mid");
    send(1'b0, 1'b0, "rst_mid");
    reset = 1'b1;
    send(1'b1, 1'b0, "rst_edge");
    reset = 1'b0;
    chk("rst_mid_cnt", {24'b0, match_cnt}, 32'd0);
    send(1'b1, 1'b0, "rst_after");

    // Reset while y=1 clears y and the count.
    send(1'b0, 1'b0, "rst_y");
    send(1'b0, 1'b0, "rst_y");
    send(1'b1, 1'b1, "rst_y");
    reset = 1'b1;
    send(1'b0, 1'b0, "rst_y_edge");
    reset = 1'b0;
    chk("rst_y_cnt", {24'b0, match_cnt}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
